apb_cmd_master: RTL and testbench

//  Upstream APB requester for the register-bank slave (apb_top).

---
 rtl/apb_cmd_master.sv | 151 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB requester: turns single read/write commands into one SETUP/ACCESS transfer each
// and returns read data plus error/timeout status on a valid/ready response channel.
module apb_cmd_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  // APB requester port
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]        state,       state_d;
  logic [CNT_W-1:0]  wait_cnt,    wait_cnt_d;
  logic              psel_d,      penable_d,   pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  // Only IDLE takes a command; reset masks it immediately.
  assign cmd_ready = (state == ST_IDLE) && !preset;

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_slverr  <= rsp_slverr_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

  // Next-state and next-output decode; everything holds unless a transition says otherwise.
  always_comb begin
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_slverr_d  = rsp_slverr;
    rsp_timeout_d = rsp_timeout;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end

      ST_SETUP: begin
        state_d    = ST_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end

      ST_ACCESS: begin
        // pready wins over an expiring watchdog on the same cycle
        if (pready) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (!pwrite && !pslverr) ? prdata : '0;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (wait_cnt == CNT_LAST) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table, hand-written reset/pending cases,
// and random transactions checked against a transaction-level model of the requester.
module tb_apb_cmd_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO     = 16;

  logic              pclk = 1'b0;
  logic              preset = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_slverr, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready = 1'b0, pslverr = 1'b0;
  logic [DATA_W-1:0] prdata = '0;

  always #5 pclk = ~pclk;

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;    // ACCESS cycles with pready=0 before the slave answers
    logic        ferr;     // slave forces pslverr
    int          rdly;     // cycles rsp_ready held low (0 = held high throughout)
    logic        pend;     // keep the next command pending during the response
    logic [31:0] e_rdata;
    logic        e_slverr;
    logic        e_to;
    int          e_lat;    // response cycle, counting the SETUP cycle as N+1
    int          e_pen;    // cycles with penable high
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cur   = 0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL txn%0d %s: got 0x%0h expected 0x%0h", cur, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Transaction-level expectation from the requester's documented rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic to, err;
    r   = v;
    to  = (v.waits >= int'(TO));
    err = to || v.ferr || (v.addr > 32'd767);
    r.e_to     = to;
    r.e_slverr = err;
    r.e_rdata  = (v.wr || err) ? 32'h0 : (ref_mem.exists(v.addr) ? ref_mem[v.addr] : 32'h0);
    r.e_lat    = to ? int'(TO) + 2 : v.waits + 3;
    r.e_pen    = to ? int'(TO) : v.waits + 1;
    return r;
  endfunction

  function automatic void model_commit(input vec_t v);
    if (v.wr && (v.waits < int'(TO)) && !v.ferr && (v.addr <= 32'd767))
      ref_mem[v.addr] = v.wdata;
  endfunction

  // Issues one command, plays the APB slave, checks timing and the response.
  task automatic run_txn(input vec_t v, input vec_t nx);
    int   cyc, pen, psel_n, hold_bad;
    logic fields_ok, err_now;
    err_now   = v.ferr || (v.addr > 32'd767);
    rsp_ready = (v.rdly == 0);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cyc = 0; pen = 0; psel_n = 0; fields_ok = 1'b1;
    while (!rsp_valid && cyc < 40) begin
      if (psel) begin
        psel_n++;
        if (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata) fields_ok = 1'b0;
      end
      if (psel && penable) begin
        pen++;
        if (pen - 1 == v.waits) begin
          pready  = 1'b1;
          pslverr = err_now;
          prdata  = err_now ? $urandom : (slave_mem.exists(v.addr) ? slave_mem[v.addr] : 32'h0);
          if (v.wr && !err_now) slave_mem[v.addr] = v.wdata;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        end
      end else begin
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
      step();
      cyc++;
    end
    chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    chk("latency", 64'(cyc + 1), 64'(v.e_lat));
    chk("penable_cycles", 64'(pen), 64'(v.e_pen));
    chk("psel_cycles", 64'(psel_n), 64'(v.e_pen + 1));
    chk("apb_fields_stable", 64'(fields_ok), 64'd1);
    chk("rsp_rdata", 64'(rsp_rdata), 64'(v.e_rdata));
    chk("rsp_slverr", 64'(rsp_slverr), 64'(v.e_slverr));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(v.e_to));
    hold_bad = 0;
    for (int i = 0; i < v.rdly; i++) begin
      if (v.pend) begin
        cmd_valid = 1'b1; cmd_write = nx.wr; cmd_addr = nx.addr; cmd_wdata = nx.wdata;
      end else begin
        cmd_valid = 1'($urandom); cmd_addr = $urandom;
      end
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      step();
      if (!rsp_valid || rsp_rdata !== v.e_rdata || rsp_slverr !== v.e_slverr ||
          rsp_timeout !== v.e_to || cmd_ready || psel || penable) hold_bad++;
    end
    chk("resp_hold_stable", 64'(hold_bad), 64'd0);
    if (v.pend) begin
      cmd_valid = 1'b1; cmd_write = nx.wr; cmd_addr = nx.addr; cmd_wdata = nx.wdata;
    end else begin
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    step();
    chk("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_after_hs", 64'(cmd_ready), 64'd1);
    chk("psel_after_hs", 64'(psel), 64'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vt[9];
    vec_t v, nx;
    int   rsp_seen;

    //       wr    addr      wdata         waits ferr  rdly pend  e_rdata       e_err e_to lat pen
    vt[0] = '{1'b1, 32'h010, 32'h12345678, 0,    1'b0, 0,   1'b0, 32'h0,        1'b0, 1'b0, 3,  1};
    vt[1] = '{1'b0, 32'h010, 32'h0,        3,    1'b0, 5,   1'b1, 32'h12345678, 1'b0, 1'b0, 6,  4};
    vt[2] = '{1'b0, 32'h400, 32'h0,        0,    1'b0, 0,   1'b0, 32'h0,        1'b1, 1'b0, 3,  1};
    vt[3] = '{1'b0, 32'h020, 32'h0,        99,   1'b0, 0,   1'b0, 32'h0,        1'b1, 1'b1, 18, 16};
    vt[4] = '{1'b0, 32'h010, 32'h0,        15,   1'b0, 2,   1'b0, 32'h12345678, 1'b0, 1'b0, 18, 16};
    vt[5] = '{1'b1, 32'h024, 32'hCAFEF00D, 2,    1'b1, 0,   1'b0, 32'h0,        1'b1, 1'b0, 5,  3};
    vt[6] = '{1'b0, 32'h024, 32'h0,        0,    1'b0, 1,   1'b0, 32'h0,        1'b0, 1'b0, 3,  1};
    vt[7] = '{1'b1, 32'h020, 32'h0000A5A5, 16,   1'b0, 0,   1'b0, 32'h0,        1'b1, 1'b1, 18, 16};
    vt[8] = '{1'b0, 32'h020, 32'h0,        0,    1'b0, 3,   1'b0, 32'h0,        1'b0, 1'b0, 3,  1};

    // Reset state
    step(); step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    preset = 1'b0;
    #1;
    chk("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      cur = i;
      run_txn(vt[i], (i < 8) ? vt[i+1] : vt[i]);
      model_commit(vt[i]);
    end

    // Reset pulsed in the middle of ACCESS aborts the transfer without a response.
    cur = 100;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'h0;
    pready = 1'b0; rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_access_penable", 64'(penable), 64'd1);
    step(); step();
    preset = 1'b1;
    step();
    chk("mid_rst_psel", 64'(psel), 64'd0);
    chk("mid_rst_penable", 64'(penable), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_paddr", 64'(paddr), 64'd0);
    preset = 1'b0;
    #1;
    chk("mid_rst_release_cmd_ready", 64'(cmd_ready), 64'd1);
    rsp_seen = 0;
    for (int i = 0; i < 20; i++) begin
      pready = 1'($urandom);
      step();
      if (rsp_valid || psel) rsp_seen++;
    end
    chk("mid_rst_no_rsp", 64'(rsp_seen), 64'd0);
    rsp_ready = 1'b0;

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      int r;
      cur    = 200 + i;
      v.wr   = 1'($urandom);
      v.addr = (($urandom_range(0, 7)) == 0) ? 32'h300 + 32'($urandom_range(0, 255))
                                            : 32'($urandom_range(0, 15)) * 32'd4;
      v.wdata = $urandom;
      r = int'($urandom_range(0, 9));
      v.waits = (r < 6) ? int'($urandom_range(0, 3)) :
                (r < 8) ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 30));
      v.ferr = ($urandom_range(0, 9) == 0);
      v.rdly = int'($urandom_range(0, 3));
      v.pend = 1'b0;
      v  = model(v);
      nx = v;
      run_txn(v, nx);
      model_commit(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
